light_countdown_display: RTL and testbench
==========================================

// Module: light_countdown_display
// PURPOSE
//  Downstream of the traffic-light FSM on the Nexys A7 board. Consumes the red/yellow/green
//  phase outputs and the 1 Hz tick, then shows the remaining seconds of the current phase.
//  Drives a 3-digit multiplexed seven-segment display: phase letter plus two-digit countdown.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock in Hz
//  REFRESH_HZ  1000         digit-slot advance rate; REFRESH_DIV = CLK_FREQ/REFRESH_HZ cycles
//  RED_SEC     50           countdown load value for red phase (clamped to 99)
//  YELLOW_SEC  10           countdown load value for yellow phase (clamped to 99)
//  GREEN_SEC   50           countdown load value for green phase (clamped to 99)
// PORTS
//  clk       in   1  system clock; sole clock
//  rst       in   1  synchronous, active-high reset
//  tick_1hz  in   1  one-clk-wide pulse, once per second
//  red       in   1  red phase active
//  yellow    in   1  yellow phase active
//  green     in   1  green phase active
//  an        out  8  digit anodes, active-low; an[0]=ones, an[1]=tens, an[2]=letter, an[7:3]=1
//  seg       out  7  {g,f,e,d,c,b,a}, active-low
//  dp        out  1  decimal point, active-low; constant 1
// BEHAVIOUR
//  Reset (sync) values:
//   - an=8'hFF, seg=7'h7F, dp=1, remaining=0, prev_phase=INVALID
//   - refresh counter=0, digit_sel=0
//  Phase decode:
//   - exactly one of red/yellow/green high -> RED/YEL/GRN
//   - none or more than one high -> INVALID
//  Countdown register (remaining, 7 bit):
//   - cycle N: phase != prev_phase and phase valid -> cycle N+1: remaining = that phase's *_SEC
//   - load has priority over a tick_1hz in the same cycle
//   - otherwise tick_1hz with remaining>0 -> decrement; remaining==0 -> hold 0 (no wrap)
//   - INVALID -> remaining forced to 0
//   - prev_phase updates every cycle
//  Refresh:
//   - counter 0..REFRESH_DIV-1; at terminal count it wraps and digit_sel steps 0->1->2->0
//  Output register (1 cycle after digit_sel/remaining change):
//   - digit_sel drives its anode low; all other anodes high
//   - slot 0: ones = remaining%10
//   - slot 1: tens = remaining/10; blank (7'h7F) when tens==0
//   - slot 2: letter
//  Encodings:
//   - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
//   - r=7'h2F, Y=7'h11, G=7'h42, dash=7'h3F
//   - INVALID: dash on all three slots
//  Latency: phase change -> new value visible within 1 + 3*REFRESH_DIV cycles worst case.
//  rst mid-count: all state returns to reset values; the next valid phase reloads.
// CONFIGURATION
//  BLINK_LAST_EN defined:
//   - half-second counter cleared on tick_1hz
//   - remaining<=3, phase valid and counter >= CLK_FREQ/2 -> an forced 8'hFF
//   - blanking also covers the letter slot
//  BLINK_LAST_EN undefined:
//   - no half-second counter; display steady at all times
// TESTING (sim: CLK_FREQ=40, REFRESH_HZ=10 -> REFRESH_DIV=4)
//  1 rst held 3 clks -> an=8'hFF, seg=7'h7F, dp=1. Release with red=1 -> remaining=50;
//    slots: ones=7'h40, tens=7'h12, letter=7'h2F.
//  2 red held, 7 ticks -> remaining=43. 43 more ticks -> 0. Extra ticks -> stays 0;
//    tens slot blank.
//  3 red->yellow in the same cycle as a tick -> remaining=10, not 9 or 49; letter=7'h11.
//  4 red=1 and green=1 -> all three slots 7'h3F, remaining=0. Then green only -> remaining=50,
//    letter=7'h42.
//  5 rst asserted at remaining=20 -> reset values next clk. Release with yellow -> 10.
//  6 BLINK_LAST_EN, remaining=3 -> an=8'hFF for clk counts 20..39 after each tick.
//    Without the macro -> never all-high while the phase is valid.

Source files
------------

// File: rtl/light_countdown_display.sv
// light_countdown_display: phase letter plus two-digit countdown on a multiplexed 3-digit seven-segment display (optional BLINK_LAST_EN)
module light_countdown_display #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int RED_SEC    = 50,
    parameter int YELLOW_SEC = 10,
    parameter int GREEN_SEC  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int REFRESH_DIV = CLK_FREQ / REFRESH_HZ;
    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] RED_LD = 7'(RED_SEC > 99 ? 99 : RED_SEC);
    localparam logic [6:0] YEL_LD = 7'(YELLOW_SEC > 99 ? 99 : YELLOW_SEC);
    localparam logic [6:0] GRN_LD = 7'(GREEN_SEC > 99 ? 99 : GREEN_SEC);
    localparam logic [6:0] DIG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef enum logic [1:0] {INVALID, RED, YEL, GRN} phase_t;

    phase_t          phase, prev_phase;
    logic [6:0]      remaining, load_val, letter, seg_nxt;
    logic [3:0]      ones, tens;
    logic [RW-1:0]   refresh_cnt;
    logic [1:0]      digit_sel;
    logic            blank;

    assign dp = 1'b1;

    // one-hot phase decode; anything else is treated as invalid
    always_comb begin
        phase = {red, yellow, green} == 3'b100 ? RED :
                {red, yellow, green} == 3'b010 ? YEL :
                {red, yellow, green} == 3'b001 ? GRN : INVALID;
        load_val = phase == RED ? RED_LD : phase == YEL ? YEL_LD : GRN_LD;
    end

    // countdown: reload on phase entry (wins over tick), saturate at zero, clear when invalid
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining  <= '0;
            prev_phase <= INVALID;
        end else begin
            prev_phase <= phase;
            if (phase == INVALID)
                remaining <= '0;
            else if (phase != prev_phase)
                remaining <= load_val;
            else if (tick_1hz && remaining != 7'd0)
                remaining <= remaining - 7'd1;
        end
    end

    // refresh divider stepping the active digit slot 0->1->2->0
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_sel   <= '0;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_sel   <= digit_sel == 2'd2 ? 2'd0 : digit_sel + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // segment pattern for the active slot; prev_phase is the phase that remaining reflects
    always_comb begin
        ones    = 4'(remaining % 7'd10);
        tens    = 4'(remaining / 7'd10);
        letter  = prev_phase == RED ? 7'h2F : prev_phase == YEL ? 7'h11 : 7'h42;
        seg_nxt = prev_phase == INVALID ? 7'h3F :
                  digit_sel == 2'd0 ? DIG[ones] :
                  digit_sel == 2'd1 ? (tens == 4'd0 ? 7'h7F : DIG[tens]) : letter;
    end

`ifdef BLINK_LAST_EN
    localparam int HW = $clog2(CLK_FREQ + 1);
    logic [HW-1:0] half_cnt;

    // time since the last tick, saturating at one second
    always_ff @(posedge clk) begin
        if (rst || tick_1hz)
            half_cnt <= '0;
        else if (half_cnt != HW'(CLK_FREQ))
            half_cnt <= half_cnt + 1'b1;
    end

    assign blank = remaining <= 7'd3 && prev_phase != INVALID && half_cnt >= HW'(CLK_FREQ / 2);
`else
    assign blank = 1'b0;
`endif

    // registered anode/segment drive
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
        end else begin
            an  <= blank ? 8'hFF : {5'h1F, ~(3'b001 << digit_sel)};
            seg <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_light_countdown_display.sv
// tb_light_countdown_display: vector table plus scoreboard of expected slot patterns
module tb_light_countdown_display;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       red = 1'b0, yellow = 1'b0, green = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int failures = 0;

    light_countdown_display #(
        .CLK_FREQ(40), .REFRESH_HZ(10), .RED_SEC(50), .YELLOW_SEC(10), .GREEN_SEC(50)
    ) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .red(red), .yellow(yellow),
        .green(green), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, y, g, tw;
        int         ticks;
        logic [6:0] rem, s0, s1, s2;
    } vec_t;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
    } exp_t;

    vec_t v[12];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) tick_1hz = 1'b1;
        @(negedge clk) tick_1hz = 1'b0;
    endtask

    task automatic drain(input int idx);
        exp_t e;
        bit found;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            found = 0;
            for (int k = 0; k < 20 && !found; k++) begin
                @(negedge clk);
                found = an == e.an;
            end
            checks++;
            if (!found) begin
                failures++;
                $display("FAIL slot_timeout v%0d: an=%0h never reached %0h", idx, an, e.an);
            end else if (seg !== e.seg) begin
                failures++;
                $display("FAIL slot_seg v%0d an=%0h: got %0h expected %0h", idx, e.an, seg, e.seg);
            end
        end
    endtask

    initial begin
        int ff_cnt;
        v[0]  = '{1, 0, 0, 0, 0,  7'd50, 7'h40, 7'h12, 7'h2F};
        v[1]  = '{1, 0, 0, 0, 7,  7'd43, 7'h30, 7'h19, 7'h2F};
        v[2]  = '{1, 0, 0, 0, 43, 7'd0,  7'h40, 7'h7F, 7'h2F};
        v[3]  = '{1, 0, 0, 0, 3,  7'd0,  7'h40, 7'h7F, 7'h2F};
        v[4]  = '{0, 1, 0, 1, 0,  7'd10, 7'h40, 7'h79, 7'h11};
        v[5]  = '{0, 1, 0, 0, 4,  7'd6,  7'h02, 7'h7F, 7'h11};
        v[6]  = '{1, 0, 1, 0, 2,  7'd0,  7'h3F, 7'h3F, 7'h3F};
        v[7]  = '{0, 0, 1, 0, 0,  7'd50, 7'h40, 7'h12, 7'h42};
        v[8]  = '{0, 0, 1, 0, 31, 7'd19, 7'h10, 7'h79, 7'h42};
        v[9]  = '{0, 0, 0, 0, 0,  7'd0,  7'h3F, 7'h3F, 7'h3F};
        v[10] = '{1, 0, 0, 1, 0,  7'd50, 7'h40, 7'h12, 7'h2F};
        v[11] = '{0, 1, 0, 0, 7,  7'd3,  7'h30, 7'h7F, 7'h11};

        repeat (3) @(negedge clk);
        chk("reset_an", an, 8'hFF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_dp", dp, 1'b1);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst = 1'b0;
            {red, yellow, green} = {v[i].r, v[i].y, v[i].g};
            tick_1hz = v[i].tw;
            @(negedge clk) tick_1hz = 1'b0;
            for (int t = 0; t < v[i].ticks; t++) tick();
            repeat (2) @(negedge clk);
            chk($sformatf("remaining_v%0d", i), dut.remaining, v[i].rem);
            sb.push_back('{8'hFE, v[i].s0});
            sb.push_back('{8'hFD, v[i].s1});
            sb.push_back('{8'hFB, v[i].s2});
            drain(i);
        end

        tick();
        ff_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (an == 8'hFF) ff_cnt++;
        end
`ifdef BLINK_LAST_EN
        chk("blink_last", ff_cnt >= 15 && ff_cnt <= 25, 1'b1);
`else
        chk("steady_display", ff_cnt, 0);
`endif

        @(negedge clk) {red, yellow, green} = 3'b001;
        for (int t = 0; t < 30; t++) tick();
        @(negedge clk);
        chk("pre_reset_rem", dut.remaining, 7'd20);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_an", an, 8'hFF);
        chk("midrst_seg", seg, 7'h7F);
        chk("midrst_dp", dp, 1'b1);
        chk("midrst_rem", dut.remaining, 7'd0);
        {red, yellow, green} = 3'b010;
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reload_after_rst", dut.remaining, 7'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
